// File: rtl/fp_adder_arbiter.sv
// Round-robin arbiter that shares one floating-point adder among N requesters.
// Holds adder operands stable, masks a stale finish flag and times out a stuck adder.
module fp_adder_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned IdW    = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned CntW   = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [32*N-1:0] req_a,
  input  logic [32*N-1:0] req_b,
  input  logic [N-1:0]    req_op,
  output logic [31:0]     add_a,
  output logic [31:0]     add_b,
  output logic            add_op,
  input  logic [31:0]     add_sum,
  input  logic            add_finish,
  input  logic            add_overflow,
  input  logic            add_underflow,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IdW-1:0]  rsp_id,
  output logic [31:0]     rsp_sum,
  output logic            rsp_zero,
  output logic            rsp_overflow,
  output logic            rsp_underflow,
  output logic            rsp_timeout,
  output logic            busy
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  ptr_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     add_a_q, add_b_q;
  logic            add_op_q;
  logic [IdW-1:0]  rsp_id_q;
  logic [31:0]     rsp_sum_q;
  logic            rsp_zero_q, rsp_ovf_q, rsp_udf_q, rsp_to_q;

  logic            gnt_found;
  logic [IdW-1:0]  gnt_idx;
  logic [IdW:0]    cand;
  logic            grant_en;
  logic            finish_ok;
  logic            cnt_last;

  // First valid requester at or after ptr, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < int'(N); k++) begin
      cand = {1'b0, ptr_q} + (IdW + 1)'(k);
      if (cand >= (IdW + 1)'(N)) cand = cand - (IdW + 1)'(N);
      if (!gnt_found && req_valid[cand[IdW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IdW-1:0];
      end
    end
  end

  assign grant_en  = (state_q == StIdle) && gnt_found && !rst;
  // finish is only trusted once the adder has had SETTLE cycles on the new operands
  assign finish_ok = (cnt_q >= CntW'(SETTLE)) && add_finish;
  assign cnt_last  = (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_en) state_d = StWait;
      StWait:  if (finish_ok || cnt_last) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (grant_en) req_ready[gnt_idx] = 1'b1;
    busy      = !rst && (state_q != StIdle);
    rsp_valid = !rst && (state_q == StResp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      cnt_q      <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      add_op_q   <= 1'b0;
      rsp_id_q   <= '0;
      rsp_sum_q  <= '0;
      rsp_zero_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
      rsp_udf_q  <= 1'b0;
      rsp_to_q   <= 1'b0;
    end else begin
      if (grant_en) begin
        add_a_q  <= req_a[32*gnt_idx +: 32];
        add_b_q  <= req_b[32*gnt_idx +: 32];
        add_op_q <= req_op[gnt_idx];
        rsp_id_q <= gnt_idx;
        ptr_q    <= (gnt_idx == IdW'(N - 1)) ? '0 : gnt_idx + IdW'(1);
        cnt_q    <= '0;
      end else if (state_q == StWait) begin
        if (cnt_q != CntW'(TIMEOUT)) cnt_q <= cnt_q + CntW'(1);
        if (finish_ok || cnt_last) begin
          rsp_sum_q  <= add_sum;
          rsp_zero_q <= (add_sum[30:0] == 31'd0);
          rsp_ovf_q  <= add_overflow;
          rsp_udf_q  <= add_underflow;
          rsp_to_q   <= !finish_ok;
        end
      end
    end
  end

  assign add_a         = add_a_q;
  assign add_b         = add_b_q;
  assign add_op        = add_op_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_sum       = rsp_sum_q;
  assign rsp_zero      = rsp_zero_q;
  assign rsp_overflow  = rsp_ovf_q;
  assign rsp_underflow = rsp_udf_q;
  assign rsp_timeout   = rsp_to_q;

endmodule
